// File: rtl/hit_judge.sv
// Whack-a-mole hit judge: tracks the lit target, judges key presses against it,
// and keeps saturating counts of hits, wrong presses and escaped targets.
module hit_judge #(
  parameter int CNT_W = 6
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             restart,
  input  logic             enable,
  input  logic [8:0]       lights,
  input  logic [3:0]       light_pos,
  input  logic             valid_key,
  input  logic [3:0]       key,
  output logic [CNT_W-1:0] score,
  output logic [CNT_W-1:0] wrong,
  output logic [CNT_W-1:0] escaped,
  output logic             hit_pulse,
  output logic             miss_pulse
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIT   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] score_q, score_d;
  logic [CNT_W-1:0] wrong_q, wrong_d;
  logic [CNT_W-1:0] escaped_q, escaped_d;
  logic             hit_q, hit_d;
  logic             miss_q, miss_d;
  logic             prev_on_q;
  logic [3:0]       prev_pos_q;

  logic on, new_tgt, key_ev, match, armed;
  logic score_inc, wrong_inc, esc_inc;

  always_comb begin
    on        = |lights;
    new_tgt   = on & (~prev_on_q | (light_pos != prev_pos_q));
    key_ev    = valid_key & enable & (key <= 4'd8);
    match     = on & (key == light_pos);
    armed     = (state_q == ARMED) | new_tgt;
    state_d   = state_q;
    score_inc = 1'b0;
    wrong_inc = 1'b0;
    esc_inc   = 1'b0;
    hit_d     = 1'b0;
    miss_d    = 1'b0;

    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (new_tgt) state_d = ARMED;
        ARMED: begin
          if (!on) begin
            state_d = IDLE;
            esc_inc = 1'b1;
          end else if (new_tgt) begin
            esc_inc = 1'b1;
          end
        end
        HIT: begin
          if (!on)          state_d = IDLE;
          else if (new_tgt) state_d = ARMED;
        end
        default: state_d = IDLE;
      endcase

      // A hit overrides the base transition; a repeat press on an already-hit
      // target is silently absorbed; everything else is a wrong press.
      if (key_ev) begin
        if (match && armed) begin
          score_inc = 1'b1;
          hit_d     = 1'b1;
          state_d   = HIT;
        end else if (!(match && state_q == HIT)) begin
          wrong_inc = 1'b1;
          miss_d    = 1'b1;
        end
      end
    end

    score_d   = (score_inc && score_q != '1)   ? score_q + ONE   : score_q;
    wrong_d   = (wrong_inc && wrong_q != '1)   ? wrong_q + ONE   : wrong_q;
    escaped_d = (esc_inc && escaped_q != '1)   ? escaped_q + ONE : escaped_q;
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      score_q    <= '0;
      wrong_q    <= '0;
      escaped_q  <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      prev_on_q  <= 1'b0;
      prev_pos_q <= '0;
    end else if (restart) begin
      state_q    <= IDLE;
      score_q    <= '0;
      wrong_q    <= '0;
      escaped_q  <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      prev_on_q  <= 1'b0;
      prev_pos_q <= '0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      wrong_q    <= wrong_d;
      escaped_q  <= escaped_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      prev_on_q  <= on;
      prev_pos_q <= light_pos;
    end
  end

  assign score      = score_q;
  assign wrong      = wrong_q;
  assign escaped    = escaped_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;

endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge: directed vector table, hand sequences for saturation and
// reset corners, then random traffic against a target-level reference model.
module tb_hit_judge;

  localparam int CNT_W = 6;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             restart, enable, valid_key;
  logic [8:0]       lights;
  logic [3:0]       light_pos, key;
  logic [CNT_W-1:0] score, wrong, escaped;
  logic             hit_pulse, miss_pulse;

  int tests = 0;
  int fails = 0;

  hit_judge #(.CNT_W(CNT_W)) dut (
    .CLOCK_50  (clk),
    .reset     (rst_n),
    .restart   (restart),
    .enable    (enable),
    .lights    (lights),
    .light_pos (light_pos),
    .valid_key (valid_key),
    .key       (key),
    .score     (score),
    .wrong     (wrong),
    .escaped   (escaped),
    .hit_pulse (hit_pulse),
    .miss_pulse(miss_pulse)
  );

  always #10 clk = ~clk;

  // Reference model: thinks in terms of "is there a live target, and has it
  // been hit yet", with plain integer counters clipped at MAXC.
  int   ms, mw, me;
  bit   mh, mm;
  bit   m_live, m_hit, m_pon;
  logic [3:0] m_ppos;

  function automatic int inc(int v);
    return (v < MAXC) ? v + 1 : v;
  endfunction

  function automatic logic [8:0] lit(input logic [3:0] p);
    logic [8:0] one;
    one = 9'd1;
    return (p <= 4'd8) ? (one << p) : 9'd0;
  endfunction

  task automatic model_clear();
    ms = 0; mw = 0; me = 0; mh = 0; mm = 0;
    m_live = 0; m_hit = 0; m_pon = 0; m_ppos = '0;
  endtask

  task automatic model_step();
    bit on, nt;
    if (restart) begin
      model_clear();
      return;
    end
    on = (lights != 0);
    nt = on && (!m_pon || light_pos != m_ppos);
    mh = 0; mm = 0;
    if (enable) begin
      if (m_live && !m_hit && (!on || nt)) me = inc(me);
      if (nt) begin
        m_live = 1; m_hit = 0;
      end else if (!on) begin
        m_live = 0;
      end
      if (valid_key && key <= 8) begin
        if (on && m_live && key == light_pos) begin
          if (!m_hit) begin
            ms = inc(ms); mh = 1; m_hit = 1;
          end
        end else begin
          mw = inc(mw); mm = 1;
        end
      end
    end else begin
      m_live = 0;
    end
    m_pon = on; m_ppos = light_pos;
  endtask

  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int s, input int w, input int e,
                         input int h, input int m);
    chk({tag, ".score"},   int'(score),      s);
    chk({tag, ".wrong"},   int'(wrong),      w);
    chk({tag, ".escaped"}, int'(escaped),    e);
    chk({tag, ".hit"},     int'(hit_pulse),  h);
    chk({tag, ".miss"},    int'(miss_pulse), m);
  endtask

  task automatic step(input bit rs, input bit en, input logic [8:0] li,
                      input logic [3:0] pos, input bit vk, input logic [3:0] k);
    @(negedge clk);
    restart = rs; enable = en; lights = li; light_pos = pos;
    valid_key = vk; key = k;
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    bit         en;
    logic [3:0] pos;
    bit         on;
    bit         vk;
    logic [3:0] k;
    int         s, w, e;
    bit         h, m;
  } vec_t;

  vec_t vt[21];

  initial begin
    rst_n = 1'b0; restart = 0; enable = 0; lights = '0; light_pos = '0;
    valid_key = 0; key = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;

    //          en pos on vk key  s  w  e  h  m
    vt[0]  = '{1, 0, 0, 0, 0,   0, 0, 0, 0, 0};
    vt[1]  = '{1, 4, 1, 0, 0,   0, 0, 0, 0, 0};
    vt[2]  = '{1, 4, 1, 0, 0,   0, 0, 0, 0, 0};
    vt[3]  = '{1, 4, 1, 1, 4,   1, 0, 0, 1, 0};
    vt[4]  = '{1, 4, 1, 0, 0,   1, 0, 0, 0, 0};
    vt[5]  = '{1, 4, 1, 1, 4,   1, 0, 0, 0, 0};
    vt[6]  = '{1, 4, 0, 0, 0,   1, 0, 0, 0, 0};
    vt[7]  = '{1, 0, 0, 1, 3,   1, 1, 0, 0, 1};
    vt[8]  = '{1, 0, 0, 1, 12,  1, 1, 0, 0, 0};
    vt[9]  = '{1, 2, 1, 0, 0,   1, 1, 0, 0, 0};
    vt[10] = '{1, 2, 1, 0, 0,   1, 1, 0, 0, 0};
    vt[11] = '{1, 2, 0, 0, 0,   1, 1, 1, 0, 0};
    vt[12] = '{1, 7, 1, 1, 7,   2, 1, 1, 1, 0};
    vt[13] = '{1, 7, 1, 0, 0,   2, 1, 1, 0, 0};
    vt[14] = '{1, 7, 1, 1, 7,   2, 1, 1, 0, 0};
    vt[15] = '{1, 1, 1, 0, 0,   2, 1, 1, 0, 0};
    vt[16] = '{1, 5, 1, 1, 5,   3, 1, 2, 1, 0};
    vt[17] = '{0, 5, 1, 1, 3,   3, 1, 2, 0, 0};
    vt[18] = '{1, 5, 1, 0, 0,   3, 1, 2, 0, 0};
    vt[19] = '{1, 5, 1, 1, 5,   3, 2, 2, 0, 1};
    vt[20] = '{1, 5, 0, 0, 0,   3, 2, 2, 0, 0};

    for (int i = 0; i < 21; i++) begin
      step(0, vt[i].en, vt[i].on ? lit(vt[i].pos) : 9'd0, vt[i].pos, vt[i].vk, vt[i].k);
      chk_all($sformatf("vec%0d", i), vt[i].s, vt[i].w, vt[i].e, vt[i].h, vt[i].m);
    end

    // Saturation: a fresh target every cycle, each hit on arrival.
    step(1, 1, 9'd0, 0, 0, 0);
    chk_all("restart1", 0, 0, 0, 0, 0);
    for (int i = 0; i < 70; i++) begin
      logic [3:0] p;
      p = 4'(i % 2);
      step(0, 1, lit(p), p, 1, p);
    end
    chk_all("sat", MAXC, 0, 0, 1, 0);
    step(1, 1, 9'd0, 0, 0, 0);
    chk_all("restart2", 0, 0, 0, 0, 0);

    // Asynchronous reset while a target is armed must not count an escape.
    step(0, 1, lit(4'd3), 3, 0, 0);
    step(0, 1, lit(4'd3), 3, 0, 0);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0);
    model_clear();
    lights = '0;
    @(negedge clk) rst_n = 1'b1;
    step(0, 1, 9'd0, 3, 0, 0);
    chk_all("post_rst", 0, 0, 0, 0, 0);

    // Random traffic against the model.
    begin
      logic [3:0] rpos;
      bit         ron, ren;
      rpos = 4'd0; ron = 0; ren = 1;
      for (int i = 0; i < 3000; i++) begin
        bit         rs, vk;
        logic [3:0] k;
        logic [8:0] li;
        rs = ($urandom_range(0, 63) == 0);
        if ($urandom_range(0, 15) == 0) ren = ~ren;
        if ($urandom_range(0, 5) == 0) begin
          ron  = ($urandom_range(0, 3) != 0);
          rpos = 4'($urandom_range(0, 8));
        end
        li = ron ? lit(rpos) : 9'd0;
        if (ron && $urandom_range(0, 7) == 0) li = 9'($urandom_range(1, 511));
        vk = ($urandom_range(0, 2) == 0);
        k  = ($urandom_range(0, 1) == 0) ? rpos : 4'($urandom_range(0, 15));
        step(rs, ren, li, rpos, vk, k);
        chk_all($sformatf("rnd%0d", i), ms, mw, me, int'(mh), int'(mm));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
